fc_out_serializer: RTL and testbench

Converts the parallel accumulator vector produced by an FC input layer back into a serial sample stream for the next layer. It captures one `NUM_NUERONS`-wide vector on a single-cycle valid pulse and requantizes each element to `DATA_WIDTH` bits, applying optional ReLU, an arithmetic right shift and saturation. It then emits the elements one per accepted handshake, index 0 first. It sits between an FC layer's `fc_out`/`valid_out` and the `valid_in`/`input_data` port of the following layer or the output interface.

---
 rtl/fc_out_serializer.sv | 114 +++++++++++
 tb/tb_fc_out_serializer.sv | 387 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fc_out_serializer.sv
// fc_out_serializer: requantizes an FC accumulator vector and
// streams it out one element per valid/ready handshake.
module fc_out_serializer #(
  parameter int NUM_NUERONS = 8,
  parameter int ACC_WIDTH   = 32,
  parameter int DATA_WIDTH  = 8,
  parameter int OUT_SHIFT   = 8,
  parameter int RELU_EN     = 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  input  logic signed [ACC_WIDTH-1:0]  fc_in [NUM_NUERONS],
  output logic                         in_ready,
  output logic                         out_valid,
  output logic signed [DATA_WIDTH-1:0] out_data,
  output logic                         out_last,
  input  logic                         out_ready,
  output logic                         overflow
);

  localparam int IW = $clog2(NUM_NUERONS);
  localparam int DW1 = DATA_WIDTH - 1;
  localparam int PADW = ACC_WIDTH - DATA_WIDTH + 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(NUM_NUERONS - 1);

  localparam logic signed [ACC_WIDTH-1:0] SAT_MAX =
    {{PADW{1'b0}}, {DW1{1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] SAT_MIN =
    {{PADW{1'b1}}, {DW1{1'b0}}};

  typedef enum logic {
    IDLE,
    SEND
  } state_t;

  state_t                       state;
  logic [IW-1:0]                idx;
  logic [IW-1:0]                idx_nxt;
  logic signed [DATA_WIDTH-1:0] stored [NUM_NUERONS];
  logic signed [DATA_WIDTH-1:0] q_vec  [NUM_NUERONS];
  logic                         capture;
  logic                         hs;

  function automatic logic signed [DATA_WIDTH-1:0] requant(
    input logic signed [ACC_WIDTH-1:0] v
  );
    logic signed [ACC_WIDTH-1:0] r;
    logic signed [ACC_WIDTH-1:0] s;
    r = (RELU_EN != 0 && v[ACC_WIDTH-1]) ? '0 : v;
    s = r >>> OUT_SHIFT;
    if (s > SAT_MAX) begin
      return SAT_MAX[DATA_WIDTH-1:0];
    end else if (s < SAT_MIN) begin
      return SAT_MIN[DATA_WIDTH-1:0];
    end
    return s[DATA_WIDTH-1:0];
  endfunction

  // requantize every incoming element in parallel
  always_comb begin
    for (int i = 0; i < NUM_NUERONS; i++) begin
      q_vec[i] = requant(fc_in[i]);
    end
  end

  // a new vector fits when idle or when the last sample leaves now
  assign in_ready = (state == IDLE) || (out_last && out_ready);
  assign capture  = in_valid && in_ready;
  assign hs       = out_valid && out_ready;
  assign idx_nxt  = idx + IW'(1);

  // capture/stream state machine with registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      idx       <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
      overflow  <= 1'b0;
      for (int i = 0; i < NUM_NUERONS; i++) begin
        stored[i] <= '0;
      end
    end else begin
      if (in_valid && !in_ready) begin
        overflow <= 1'b1;
      end
      if (capture) begin
        for (int i = 0; i < NUM_NUERONS; i++) begin
          stored[i] <= q_vec[i];
        end
        state     <= SEND;
        idx       <= '0;
        out_valid <= 1'b1;
        out_data  <= q_vec[0];
        out_last  <= 1'b0;
      end else if (hs) begin
        if (out_last) begin
          state     <= IDLE;
          idx       <= '0;
          out_valid <= 1'b0;
          out_data  <= '0;
          out_last  <= 1'b0;
        end else begin
          idx      <= idx_nxt;
          out_data <= stored[idx_nxt];
          out_last <= (idx_nxt == LAST_IDX);
        end
      end
    end
  end

endmodule

// File: tb/tb_fc_out_serializer.sv
// tb_fc_out_serializer: directed and randomized checks of
// fc_out_serializer against a queue-based reference model.
module tb_fc_out_serializer;

  localparam int N  = 4;
  localparam int SH = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst_n;
  logic              in_valid_a, out_ready_a;
  logic signed [31:0] fc_a [N];
  logic              in_ready_a, out_valid_a;
  logic              out_last_a, overflow_a;
  logic signed [7:0] out_data_a;

  logic              in_valid_b, out_ready_b;
  logic signed [31:0] fc_b [N];
  logic              in_ready_b, out_valid_b;
  logic              out_last_b, overflow_b;
  logic signed [7:0] out_data_b;

  int vecs = 0;
  int errs = 0;

  fc_out_serializer #(
    .NUM_NUERONS(N), .ACC_WIDTH(32), .DATA_WIDTH(8),
    .OUT_SHIFT(SH), .RELU_EN(1)
  ) u_relu (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_a),
    .fc_in(fc_a), .in_ready(in_ready_a),
    .out_valid(out_valid_a), .out_data(out_data_a),
    .out_last(out_last_a), .out_ready(out_ready_a),
    .overflow(overflow_a)
  );

  fc_out_serializer #(
    .NUM_NUERONS(N), .ACC_WIDTH(32), .DATA_WIDTH(8),
    .OUT_SHIFT(SH), .RELU_EN(0)
  ) u_lin (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_b),
    .fc_in(fc_b), .in_ready(in_ready_b),
    .out_valid(out_valid_b), .out_data(out_data_b),
    .out_last(out_last_b), .out_ready(out_ready_b),
    .overflow(overflow_b)
  );

  // floor division by 2^SH, then clamp to the signed 8-bit range
  function automatic int ref_q(longint v, bit relu);
    longint r, d, s;
    d = longint'(1) << SH;
    r = (relu && v < 0) ? 0 : v;
    if (r >= 0) s = r / d;
    else s = -((-r + d - 1) / d);
    if (s > 127) s = 127;
    if (s < -128) s = -128;
    return int'(s);
  endfunction

  function automatic logic signed [31:0] rnd_acc();
    if ($urandom_range(0, 2) == 0) return $urandom;
    return 32'(int'($urandom_range(0, 80000)) - 40000);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    in_valid_a = 1'b0; out_ready_a = 1'b0;
    in_valid_b = 1'b0; out_ready_b = 1'b0;
    for (int i = 0; i < N; i++) begin
      fc_a[i] = '0; fc_b[i] = '0;
    end
    step(); step();
    @(negedge clk);
    vecs++;
    if ({out_valid_a, out_last_a, in_ready_a, overflow_a} !== 4'b0010) begin
      errs++;
      $display("FAIL reset_flags_a: got %b want 0010",
        {out_valid_a, out_last_a, in_ready_a, overflow_a});
    end
    vecs++;
    if (out_data_a !== 8'sd0) begin
      errs++;
      $display("FAIL reset_data_a: got %0d want 0", out_data_a);
    end
    vecs++;
    if ({out_valid_b, in_ready_b, overflow_b} !== 3'b010) begin
      errs++;
      $display("FAIL reset_flags_b: got %b want 010",
        {out_valid_b, in_ready_b, overflow_b});
    end
    step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_basic();
    int exp_d[N];
    exp_d = '{1, 0, 127, 5};
    fc_a = '{256, -256, 65536, 1408};
    in_valid_a = 1'b1; out_ready_a = 1'b1;
    @(negedge clk);
    vecs++;
    if (in_ready_a !== 1'b1) begin
      errs++;
      $display("FAIL basic_idle_ready: got %b want 1", in_ready_a);
    end
    step();
    in_valid_a = 1'b0;
    fc_a = '{-5, -5, -5, -5};
    for (int k = 0; k < N; k++) begin
      @(negedge clk);
      vecs++;
      if (out_valid_a !== 1'b1 || int'(out_data_a) !== exp_d[k]) begin
        errs++;
        $display("FAIL basic_sample%0d: got v=%b d=%0d want v=1 d=%0d",
          k, out_valid_a, out_data_a, exp_d[k]);
      end
      vecs++;
      if (out_last_a !== (k == N-1) || in_ready_a !== (k == N-1)) begin
        errs++;
        $display("FAIL basic_last_ready%0d: got last=%b rdy=%b want %b",
          k, out_last_a, in_ready_a, (k == N-1));
      end
      step();
    end
    @(negedge clk);
    vecs++;
    if (out_valid_a !== 1'b0) begin
      errs++;
      $display("FAIL basic_end_valid: got %b want 0", out_valid_a);
    end
    step();
  endtask

  task automatic test_relu_off();
    int exp_d[N];
    logic signed [31:0] v [N];
    exp_d = '{-1, -128, -1, 127};
    v = '{-256, -65536, -1, 32767};
    out_ready_b = 1'b1;
    for (int t = 0; t < 6; t++) begin
      if (t > 0) begin
        for (int i = 0; i < N; i++) begin
          v[i] = rnd_acc();
          exp_d[i] = ref_q(longint'(v[i]), 1'b0);
        end
      end
      fc_b = v;
      in_valid_b = 1'b1;
      step();
      in_valid_b = 1'b0;
      for (int k = 0; k < N; k++) begin
        @(negedge clk);
        vecs++;
        if (out_valid_b !== 1'b1 || int'(out_data_b) !== exp_d[k]) begin
          errs++;
          $display("FAIL relu_off_v%0d_s%0d: in=%0d got v=%b d=%0d want %0d",
            t, k, v[k], out_valid_b, out_data_b, exp_d[k]);
        end
        step();
      end
    end
  endtask

  task automatic test_backpressure();
    bit pat[7];
    int hidx, nhs;
    pat = '{1, 0, 0, 1, 0, 1, 1};
    hidx = 0; nhs = 0;
    fc_a = '{256, 512, 768, 1024};
    in_valid_a = 1'b1; out_ready_a = 1'b1;
    step();
    in_valid_a = 1'b0;
    for (int c = 0; c < 7; c++) begin
      out_ready_a = pat[c];
      @(negedge clk);
      vecs++;
      if (out_valid_a !== 1'b1 || int'(out_data_a) !== hidx + 1
          || out_last_a !== (hidx == N-1)) begin
        errs++;
        $display("FAIL bp_cycle%0d: got v=%b d=%0d l=%b want v=1 d=%0d l=%b",
          c, out_valid_a, out_data_a, out_last_a, hidx + 1, (hidx == N-1));
      end
      if (out_valid_a && out_ready_a) nhs++;
      if (pat[c]) hidx++;
      step();
    end
    out_ready_a = 1'b1;
    @(negedge clk);
    vecs++;
    if (nhs !== N || out_valid_a !== 1'b0) begin
      errs++;
      $display("FAIL bp_handshakes: got hs=%0d v=%b want hs=%0d v=0",
        nhs, out_valid_a, N);
    end
    step();
  endtask

  task automatic test_back_to_back();
    fc_a = '{256, 512, 768, 1024};
    in_valid_a = 1'b1; out_ready_a = 1'b1;
    step();
    for (int k = 0; k < 2*N; k++) begin
      if (k == N-1) begin
        in_valid_a = 1'b1;
        fc_a = '{1280, 1536, 1792, 2048};
      end else begin
        in_valid_a = 1'b0;
      end
      @(negedge clk);
      vecs++;
      if (out_valid_a !== 1'b1 || int'(out_data_a) !== k + 1
          || out_last_a !== (k == N-1 || k == 2*N-1)) begin
        errs++;
        $display("FAIL b2b_sample%0d: got v=%b d=%0d l=%b want d=%0d",
          k, out_valid_a, out_data_a, out_last_a, k + 1);
      end
      if (k == N-1) begin
        vecs++;
        if (in_ready_a !== 1'b1) begin
          errs++;
          $display("FAIL b2b_in_ready: got %b want 1", in_ready_a);
        end
      end
      step();
    end
    in_valid_a = 1'b0;
    @(negedge clk);
    vecs++;
    if (out_valid_a !== 1'b0 || overflow_a !== 1'b0) begin
      errs++;
      $display("FAIL b2b_end: got v=%b ovf=%b want v=0 ovf=0",
        out_valid_a, overflow_a);
    end
    step();
  endtask

  task automatic test_overrun();
    fc_a = '{256, 512, 768, 1024};
    in_valid_a = 1'b1; out_ready_a = 1'b1;
    step();
    for (int k = 0; k < N + 3; k++) begin
      if (k == 1) begin
        in_valid_a = 1'b1;
        fc_a = '{2560, 2816, 3072, 3328};
      end else begin
        in_valid_a = 1'b0;
      end
      @(negedge clk);
      vecs++;
      if (k < N) begin
        if (out_valid_a !== 1'b1 || int'(out_data_a) !== k + 1) begin
          errs++;
          $display("FAIL overrun_sample%0d: got v=%b d=%0d want v=1 d=%0d",
            k, out_valid_a, out_data_a, k + 1);
        end
      end else if (out_valid_a !== 1'b0) begin
        errs++;
        $display("FAIL overrun_dropped%0d: got v=%b want 0", k, out_valid_a);
      end
      vecs++;
      if (overflow_a !== (k >= 2)) begin
        errs++;
        $display("FAIL overrun_flag%0d: got %b want %b",
          k, overflow_a, (k >= 2));
      end
      step();
    end
  endtask

  task automatic test_reset_mid();
    fc_a = '{256, 512, 768, 1024};
    in_valid_a = 1'b1; out_ready_a = 1'b1;
    step();
    in_valid_a = 1'b0;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      vecs++;
      if (int'(out_data_a) !== k + 1) begin
        errs++;
        $display("FAIL rst_mid_pre%0d: got %0d want %0d",
          k, out_data_a, k + 1);
      end
      step();
    end
    rst_n = 1'b0;
    #1;
    vecs++;
    if ({out_valid_a, in_ready_a, overflow_a} !== 3'b010
        || out_data_a !== 8'sd0) begin
      errs++;
      $display("FAIL rst_mid_async: got v=%b rdy=%b ovf=%b d=%0d want 0 1 0 0",
        out_valid_a, in_ready_a, overflow_a, out_data_a);
    end
    step(); step();
    rst_n = 1'b1;
    step();
    fc_a = '{1280, 1536, 1792, 2048};
    in_valid_a = 1'b1;
    step();
    in_valid_a = 1'b0;
    for (int k = 0; k < N; k++) begin
      @(negedge clk);
      vecs++;
      if (out_valid_a !== 1'b1 || int'(out_data_a) !== k + 5) begin
        errs++;
        $display("FAIL rst_mid_restart%0d: got v=%b d=%0d want v=1 d=%0d",
          k, out_valid_a, out_data_a, k + 5);
      end
      step();
    end
    @(negedge clk);
    vecs++;
    if (out_valid_a !== 1'b0) begin
      errs++;
      $display("FAIL rst_mid_end: got v=%b want 0", out_valid_a);
    end
    step();
  endtask

  task automatic test_random();
    int q[$];
    bit ovf, mready;
    ovf = 1'b0;
    for (int c = 0; c < 400; c++) begin
      in_valid_a  = ($urandom_range(0, 3) == 0);
      out_ready_a = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < N; i++) fc_a[i] = rnd_acc();
      @(negedge clk);
      mready = (q.size() == 0) || (q.size() == 1 && out_ready_a);
      vecs++;
      if (in_ready_a !== mready || out_valid_a !== (q.size() != 0)
          || overflow_a !== ovf) begin
        errs++;
        $display("FAIL rand_ctrl%0d: got rdy=%b v=%b ovf=%b want %b %b %b",
          c, in_ready_a, out_valid_a, overflow_a,
          mready, (q.size() != 0), ovf);
      end
      if (q.size() != 0) begin
        vecs++;
        if (int'(out_data_a) !== q[0] || out_last_a !== (q.size() == 1)) begin
          errs++;
          $display("FAIL rand_data%0d: got d=%0d l=%b want d=%0d l=%b",
            c, out_data_a, out_last_a, q[0], (q.size() == 1));
        end
        if (out_ready_a) void'(q.pop_front());
      end
      if (in_valid_a) begin
        if (mready) begin
          for (int i = 0; i < N; i++) q.push_back(ref_q(longint'(fc_a[i]), 1'b1));
        end else begin
          ovf = 1'b1;
        end
      end
      step();
    end
    in_valid_a = 1'b0;
    out_ready_a = 1'b1;
    for (int c = 0; c < 2*N; c++) step();
    @(negedge clk);
    vecs++;
    if (out_valid_a !== 1'b0) begin
      errs++;
      $display("FAIL rand_drain: got v=%b want 0", out_valid_a);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_relu_off();
    test_backpressure();
    test_back_to_back();
    test_overrun();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
